async_upcount: RTL and testbench
================================

# async_upcount

Free-running binary up-counter with a synchronous active-high reset. It increments by one on every rising clock edge and wraps modulo 2^WIDTH. It is a small utility block used as a cycle or phase counter and as a reference counting stage. Despite the historical "async" in the name, all state is clocked by the single `clk`; there is no ripple clocking between stages.

## Interface
- `WIDTH`, default 2: counter width in bits. The instance default of 2 gives a mod-4 counter. Legal range is 1 to 32.
- `clk`, input, 1: the only clock; all state updates on its rising edge.
- `rst`, input, 1: synchronous, active-high reset. It is sampled only on the rising edge of `clk`.
- `q`, output, WIDTH (default [1:0]): current count. Driven directly from registers, with no combinational path from the inputs.

## Operation
- On each rising edge of `clk`:
  - `rst` = 1: `q` <= 0.
  - `rst` = 0: `q` <= `q` + 1, modulo 2^WIDTH.
- Reset value of `q`: all zeros.
- Reset has priority over counting. There is no enable input; the counter advances every cycle while out of reset.
- Wrap-around: from all-ones, the next count is 0. No carry or overflow output exists, and no flag is raised on wrap.
- Bit structure (implementation-visible behaviour):
  - Bit 0 toggles every non-reset cycle.
  - Bit i toggles when bits [i-1:0] are all 1.
  - All bits update on the same edge, so there are no transient intermediate codes.
- Power-up: `q` is undefined (X in simulation) until the first rising edge with `rst` = 1. The block does not rely on an initial value.
- `rst` asserted mid-count: `q` becomes 0 on the next rising edge, whatever its current value. Asynchronous assertion between edges has no effect until that edge.
- `rst` held high for multiple cycles: `q` stays 0.
- `rst` deasserted before an edge: that edge counts, so `q` becomes 1.

## Timing
- Latency: one cycle.
  - `q` after an edge reflects `rst` and `q` sampled at that edge.
  - `q` changes only just after rising edges of `clk`.
- Counting sequence, with WIDTH = 2 and `rst` low from edge k onward: edge k gives 1, k+1 gives 2, k+2 gives 3, k+3 gives 0, k+4 gives 1, and so on (period 4 cycles).
- With a 10 ns clock starting low, `rst` = 1 over 0–10 ns, then 0:
  - 5 ns: `q` = 00.
  - 15 ns: 01.
  - 25 ns: 10.
  - 35 ns: 11.
  - 45 ns: 00.
  - 55 ns: 01.
  - Pattern repeats every 40 ns through 105 ns.
- `rst` must meet normal setup and hold time relative to `clk`. No metastability synchronizer is included.

## Test plan
- Reset: `rst` = 1 for one edge at 5 ns -> `q` = 00 after the edge; X before it is acceptable.
- Count and wrap: release `rst` at 10 ns and run 10 edges -> `q` = 01, 10, 11, 00, 01, 10, 11, 00, 01, 10 at 15, 25, …, 105 ns.
- Reset held: `rst` = 1 for 5 consecutive edges -> `q` stays 00 throughout. The first edge after release gives 01.
- Mid-count reset: assert `rst` for one edge when `q` = 10 -> `q` = 00 on that edge, then 01 on the next edge.
- Synchronous-only check: pulse `rst` high for 2 ns entirely between edges when `q` = 01 -> `q` is unaffected and advances to 10 on the next edge.
- Parameter check: WIDTH = 4, release `rst` -> `q` counts 1…15, then 0 on the 16th edge after release. No value is skipped or repeated.

Source files
------------

// File: rtl/async_upcount.sv
// async_upcount: free-running binary up-counter, wraps modulo 2^WIDTH.
// Every bit is clocked by clk. The "async" in the name is historical only.
// rst is synchronous and active-high, and it takes priority over counting.
// q comes straight from the count register.
module async_upcount #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] toggle;

  // Bit 0 always flips.
  // Bit i flips only when every lower bit is one, which is the carry
  // into that bit.
  assign toggle[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_toggle
      assign toggle[gi] = &count_q[gi-1:0];
    end
  endgenerate

  // Next count: flip the bits that receive a carry.
  // All-ones therefore wraps to zero with no flag raised.
  always_comb begin
    count_d = count_q ^ toggle;
  end

  // Count register.
  // Reset is sampled only at the clock edge, so a pulse that lands
  // between edges has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: tb/tb_async_upcount.sv
// Scoreboard bench for async_upcount.
// It runs two instances: the default WIDTH=2 and WIDTH=4.
// The driver pushes a hand-computed expected count after each edge.
// Per-instance monitors pop and compare on the following falling edge.
module tb_async_upcount;

  logic       clk;
  logic       rst2;
  logic       rst4;
  logic [1:0] q2;
  logic [3:0] q4;

  int checks;
  int errors;

  logic [1:0] exp2_q[$];
  logic [3:0] exp4_q[$];

  async_upcount u_dut2 (
    .clk (clk),
    .rst (rst2),
    .q   (q2)
  );

  async_upcount #(.WIDTH(4)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .q   (q4)
  );

  // 10 ns clock that starts low, so rising edges fall at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive rst2 before the edge.
  // Just after the edge, record the count the design should now show.
  task automatic step2(input logic r, input logic [1:0] e);
    rst2 = r;
    @(posedge clk);
    #1;
    exp2_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic step4(input logic r, input logic [3:0] e);
    rst4 = r;
    @(posedge clk);
    #1;
    exp4_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor for the WIDTH=2 instance.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (exp2_q.size() > 0) begin
        e = exp2_q.pop_front();
        checks++;
        if (q2 !== e) begin
          errors++;
          $display("FAIL w2_count t=%0t got=%b expected=%b", $time, q2, e);
        end
      end
    end
  end

  // Monitor for the WIDTH=4 instance.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (exp4_q.size() > 0) begin
        e = exp4_q.pop_front();
        checks++;
        if (q4 !== e) begin
          errors++;
          $display("FAIL w4_count t=%0t got=%h expected=%h", $time, q4, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
    $fatal(1, "timeout");
  end

  // Hand-computed sequences for each phase of the test.
  logic [1:0] count_seq [10] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1,
                                 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
  logic [3:0] wide_seq  [17] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6,
                                 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC,
                                 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};

  initial begin
    checks = 0;
    errors = 0;
    rst2   = 1'b1;
    rst4   = 1'b1;

    // Reset for one edge at 5 ns, then release and run 10 edges.
    step2(1'b1, 2'd0);
    foreach (count_seq[i]) step2(1'b0, count_seq[i]);

    // Hold reset for 5 edges; the first edge after release gives 1.
    for (int i = 0; i < 5; i++) step2(1'b1, 2'd0);
    step2(1'b0, 2'd1);
    step2(1'b0, 2'd2);

    // Assert reset for one edge while the count is 2.
    step2(1'b1, 2'd0);
    step2(1'b0, 2'd1);

    // The count is now 1.
    // A 2 ns reset pulse between edges must not disturb it.
    #1 rst2 = 1'b1;
    #2 rst2 = 1'b0;
    step2(1'b0, 2'd2);
    step2(1'b0, 2'd3);
    step2(1'b0, 2'd0);
    rst2 = 1'b1;

    // WIDTH=4: reset, then count through a full wrap.
    step4(1'b1, 4'h0);
    foreach (wide_seq[i]) step4(1'b0, wide_seq[i]);

    // Let the monitors drain the queues, waiting a bounded number of cycles.
    for (int i = 0; i < 10 && (exp2_q.size() > 0 || exp4_q.size() > 0); i++)
      @(negedge clk);
    #1;
    if (exp2_q.size() > 0 || exp4_q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d pending expected=0 pending",
               exp2_q.size() + exp4_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
